// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared types and helpers for the request encoder
//
// Contents:
//   enc_state_t : output-slot state (EMPTY, FULL)
//   DEF_N       : default number of request lines
//   MAX_N       : widest request vector the helpers support
//   code_width  : code width for n request lines
//   onehot      : single-bit mask for an index (callers size-cast to N)
package enc_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } enc_state_t;

   localparam int DEF_N = 4;
   localparam int MAX_N = 64;

   function automatic int code_width(input int n);
      return $clog2(n);
   endfunction

   function automatic logic [MAX_N-1:0] onehot(input int idx);
      return MAX_N'(1) << idx;
   endfunction

endpackage

// File: rtl/prio_sel.sv
// rtl/prio_sel.sv - combinational highest-set-index selector
//
// Ports:
//   vec : N-bit candidate vector
//   idx : index of the highest set bit (0 when vec is all zero)
//   any : at least one bit of vec is set
module prio_sel #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] idx,
   output logic         any
);

   // Ascending scan: later (higher) hits overwrite earlier ones, so the
   // highest set index wins.
   always_comb begin
      idx = '0;
      for (int i = 0; i < N; i++) begin
         if (vec[i]) begin
            idx = W'(i);
         end
      end
   end

   assign any = |vec;

endmodule

// File: rtl/req_encoder.sv
// rtl/req_encoder.sv - buffered priority encoder with valid/ready output
//
// Ports:
//   clk        : clock, all state updates on the rising edge
//   rst_n      : synchronous active-low reset
//   req_i      : request pulses, bit i registers request i
//   code_o     : binary index of the request held in the output slot
//   valid_o    : code_o holds a valid code
//   ready_i    : consumer accepts code_o when valid_o && ready_i
//   pending_o  : requests captured but not yet loaded into the output slot
//   overflow_o : one-cycle pulse when a request hit an already-pending bit
module req_encoder
   import enc_pkg::*;
#(
   parameter  int N = DEF_N,
   localparam int W = code_width(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req_i,
   output logic [W-1:0] code_o,
   output logic         valid_o,
   input  logic         ready_i,
   output logic [N-1:0] pending_o,
   output logic         overflow_o
);

   enc_state_t   state, state_nxt;
   logic [N-1:0] cand;
   logic [W-1:0] sel;
   logic         sel_any;
   logic         slot_free;
   logic [W-1:0] code_nxt;
   logic         valid_nxt;
   logic [N-1:0] pending_nxt;

   // Pending requests and new pulses compete together, so a request that
   // arrives in a handshake cycle can be loaded with no bubble.
   assign cand = pending_o | req_i;

   prio_sel #(
      .N (N),
      .W (W)
   ) u_prio_sel (
      .vec (cand),
      .idx (sel),
      .any (sel_any)
   );

   // ready_i only matters while a code is being offered.
   assign slot_free = (state == EMPTY) || ready_i;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      code_nxt    = code_o;
      valid_nxt   = valid_o;
      pending_nxt = cand;
      if (slot_free) begin
         if (sel_any) begin
            state_nxt   = FULL;
            code_nxt    = sel;
            valid_nxt   = 1'b1;
            pending_nxt = cand & ~N'(onehot(int'(sel)));
         end else begin
            state_nxt = EMPTY;
            valid_nxt = 1'b0;
         end
      end
   end

   // A request matching the held code lands in pending as a fresh entry;
   // overflow only looks at pending, never at the output slot.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         code_o     <= '0;
         valid_o    <= 1'b0;
         pending_o  <= '0;
         overflow_o <= 1'b0;
      end else begin
         code_o     <= code_nxt;
         valid_o    <= valid_nxt;
         pending_o  <= pending_nxt;
         overflow_o <= |(req_i & pending_o);
      end
   end

endmodule
